encoder_spi_sched: RTL and testbench



---
 rtl/encoder_pkg.sv | 19 +
 rtl/encoder_sck_gen.sv | 44 ++++
 rtl/encoder_spi_sched.sv | 197 +++++++++++++++++++
 tb/tb_encoder_spi_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and frame-layout constants for the absolute-encoder serial link.
package encoder_pkg;

  localparam int ENC_FRAME_BITS = 24;
  localparam int ENC_POS_MSB    = 21;
  localparam int ENC_POS_LSB    = 3;

  typedef logic [ENC_POS_MSB-ENC_POS_LSB:0] position_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_START,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/encoder_sck_gen.sv
// Serial clock generator: low half then high half per bit, with a strobe on the
// last clock of each high half where the master samples miso.
module encoder_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic sample_stb
);

  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             active;

  // NOTE: sequential state uses <= so every flop sees pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      sck      <= 1'b1;
      active   <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sck      <= 1'b1;
      active   <= 1'b0;
    end else begin
      active <= 1'b1;
      // The first enabled clock drops straight into the low half of bit 0.
      if (!active || half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        sck      <= ~sck;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

  // Only meaningful after at least one enabled clock; the FSM ignores it elsewhere.
  assign sample_stb = active & sck & (half_cnt == HALF_LAST);

endmodule

// File: rtl/encoder_spi_sched.sv
// Encoder read scheduler: periodic or software-triggered frame reads over the
// encoder serial link, publishing the raw frame, position and status.
module encoder_spi_sched
  import encoder_pkg::*;
#(
  parameter int CLK_DIV       = 8,
  parameter int FRAME_BITS    = ENC_FRAME_BITS,
  parameter int POS_MSB       = ENC_POS_MSB,
  parameter int POS_LSB       = ENC_POS_LSB,
  parameter int START_TIMEOUT = 16,
  parameter int PERIOD        = 5000,
  parameter int GAP           = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       start,
  input  logic                       miso,
  output logic                       sck,
  output logic                       cs_n,
  output logic [FRAME_BITS-1:0]      raw_frame,
  output logic [POS_MSB-POS_LSB:0]   position,
  output logic [2:0]                 status,
  output logic                       valid,
  output logic                       timeout_err,
  output logic                       overrun,
  output logic                       busy
);

  localparam int PER_W   = $clog2(PERIOD);
  localparam int SEQ_MAX = (GAP > 2 * CLK_DIV) ? GAP : 2 * CLK_DIV;
  localparam int SEQ_W   = $clog2(SEQ_MAX);
  localparam int TO_W    = $clog2(START_TIMEOUT + 1);

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);
  localparam logic [SEQ_W-1:0] SETUP_LAST = SEQ_W'(2 * CLK_DIV - 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST  = SEQ_W'(CLK_DIV - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST   = SEQ_W'(GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(START_TIMEOUT - 1);
  localparam logic [4:0]       BIT_LAST   = 5'(FRAME_BITS - 1);

  state_e                  state;
  logic                    miso_meta;
  logic                    miso_s;
  logic [PER_W-1:0]        period_cnt;
  logic [SEQ_W-1:0]        seq_cnt;
  logic [TO_W-1:0]         to_cnt;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-2:0]   sr;
  logic [FRAME_BITS-1:0]   frame_next;
  logic                    pending;
  logic                    trigger;
  logic                    sck_run;
  logic                    sample_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta <= 1'b1;
      miso_s    <= 1'b1;
    end else begin
      miso_meta <= miso;
      miso_s    <= miso_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!enable || period_cnt == PER_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign trigger    = start | (enable & (period_cnt == PER_LAST));
  assign frame_next = {sr, miso_s};

  // sck keeps running from the last SETUP clock until the final sample of the read.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sck_run = 1'b0;
    case (state)
      ST_SETUP:      sck_run = (seq_cnt == SETUP_LAST);
      ST_WAIT_START: sck_run = !(sample_stb && miso_s && to_cnt == TO_LAST);
      ST_SHIFT:      sck_run = !(sample_stb && bit_cnt == BIT_LAST);
      default:       sck_run = 1'b0;
    endcase
  end

  encoder_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (sck_run),
    .sck        (sck),
    .sample_stb (sample_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      raw_frame   <= '0;
      sr          <= '0;
      seq_cnt     <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
    end else begin
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= trigger & pending;

      // A trigger landing on the cycle IDLE is left merges into the read being started.
      if (state == ST_IDLE && pending) begin
        pending <= 1'b0;
      end else if (trigger) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pending) begin
            state   <= ST_SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            seq_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (seq_cnt == SETUP_LAST) begin
            state  <= ST_WAIT_START;
            to_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_WAIT_START: begin
          if (sample_stb) begin
            if (!miso_s) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              state       <= ST_HOLD;
              seq_cnt     <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (sample_stb) begin
            sr <= frame_next[FRAME_BITS-2:0];
            if (bit_cnt == BIT_LAST) begin
              raw_frame <= frame_next;
              valid     <= 1'b1;
              state     <= ST_HOLD;
              seq_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (seq_cnt == HOLD_LAST) begin
            cs_n    <= 1'b1;
            state   <= ST_GAP;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (seq_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign position = raw_frame[POS_MSB:POS_LSB];
  assign status   = raw_frame[2:0];

endmodule

// File: tb/tb_encoder_spi_sched.sv
// Scoreboard bench: an encoder pin model answers each read from a response
// queue while a monitor compares every published result against expectations.
module tb_encoder_spi_sched;
  import encoder_pkg::*;

  localparam int CLK_DIV       = 4;
  localparam int FB            = ENC_FRAME_BITS;
  localparam int START_TIMEOUT = 16;
  localparam int PERIOD        = 2000;
  localparam int GAP           = 32;
  localparam int TCLK          = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            start;
  logic            miso;
  logic            sck;
  logic            cs_n;
  logic [FB-1:0]   raw_frame;
  position_t       position;
  logic [2:0]      status;
  logic            valid;
  logic            timeout_err;
  logic            overrun;
  logic            busy;

  encoder_spi_sched #(
    .CLK_DIV       (CLK_DIV),
    .FRAME_BITS    (FB),
    .POS_MSB       (ENC_POS_MSB),
    .POS_LSB       (ENC_POS_LSB),
    .START_TIMEOUT (START_TIMEOUT),
    .PERIOD        (PERIOD),
    .GAP           (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .miso        (miso),
    .sck         (sck),
    .cs_n        (cs_n),
    .raw_frame   (raw_frame),
    .position    (position),
    .status      (status),
    .valid       (valid),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #(TCLK / 2) clk = ~clk;

  typedef struct { bit is_to; logic [FB-1:0] frame; } exp_t;
  typedef struct { bit is_to; int lead; logic [FB-1:0] frame; } resp_t;

  exp_t          sb_q[$];
  resp_t         resp_q[$];
  time           fall_t[$];
  logic [FB-1:0] model_last = '0;
  int            checks = 0;
  int            errors = 0;
  int            n_valid = 0;
  int            n_to = 0;
  int            n_ovr = 0;
  int            n_falls = 0;
  int            enc_falls = 0;
  bit            abort = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pair an encoder answer with the result the master should publish for it.
  task automatic queue_frame(input bit is_to, input int lead, input logic [FB-1:0] frame);
    resp_t r;
    exp_t  e;
    r.is_to = is_to;
    r.lead  = lead;
    r.frame = frame;
    resp_q.push_back(r);
    e.is_to = is_to;
    e.frame = is_to ? model_last : frame;
    if (!is_to) model_last = frame;
    sb_q.push_back(e);
  endtask

  function automatic logic enc_bit(input resp_t r, input int n);
    if (r.is_to || n < r.lead) return 1'b1;
    if (n == r.lead) return 1'b0;
    if (n <= r.lead + FB) return r.frame[FB - 1 - (n - r.lead - 1)];
    return 1'b1;
  endfunction

  // Encoder pin model: drives a new bit on each sck fall while selected.
  initial begin
    resp_t r;
    time   t0;
    int    rises;
    int    nsamp;
    miso = 1'b1;
    forever begin
      @(negedge cs_n);
      t0 = $time;
      fall_t.push_back(t0);
      n_falls++;
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
      end else begin
        r.is_to = 1'b1;
        r.lead  = 0;
        r.frame = '0;
        checks++;
        errors++;
        $display("FAIL unplanned_read: cs_n fell at %0t with no encoder answer queued", $time);
      end
      enc_falls = 0;
      rises     = 0;
      while (cs_n === 1'b0) begin
        @(sck or cs_n);
        if (cs_n !== 1'b0) break;
        if (sck === 1'b0) begin
          #1 miso = enc_bit(r, enc_falls);
          enc_falls++;
        end else begin
          rises++;
        end
      end
      miso  = 1'b1;
      nsamp = r.is_to ? START_TIMEOUT : r.lead + 1 + FB;
      if (!abort) begin
        check("sck_rises", 64'(rises), 64'(nsamp));
        check("cs_low_clks", 64'(($time - t0) / TCLK), 64'((2 * nsamp + 3) * CLK_DIV));
      end
      abort = 1'b0;
    end
  end

  // Monitor: every valid or timeout_err pulse consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid || timeout_err) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: valid=%b timeout_err=%b raw=%h", valid, timeout_err, raw_frame);
        end else begin
          e = sb_q.pop_front();
          check("timeout_pulse", 64'(timeout_err), 64'(e.is_to));
          check("valid_pulse", 64'(valid), 64'(!e.is_to));
          check("raw_frame", 64'(raw_frame), 64'(e.frame));
          check("position", 64'(position), 64'(e.frame / 24'd8 % 24'd524288));
          check("status", 64'(status), 64'(e.frame % 24'd8));
        end
      end
      if (valid) n_valid++;
      if (timeout_err) n_to++;
      if (overrun) n_ovr++;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0 && resp_q.size() == 0 && !busy) break;
    end
    check({"done_", name}, 64'(i < budget), 64'd1);
  endtask

  task automatic wait_falls(input string name, input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_falls >= target) break;
    end
    check({"reach_", name}, 64'(i < budget), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            v0;
    int            t0;
    int            o0;
    int            f0;
    int            idx;
    int            i;
    logic [FB-1:0] f;

    rst    = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    #1 rst = 1'b1;
    #(3 * TCLK);
    check("rst_sck", 64'(sck), 64'd1);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_raw", 64'(raw_frame), 64'd0);
    check("rst_pos", 64'(position), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Basic read with the reference frame.
    v0 = n_valid;
    queue_frame(1'b0, 0, 24'hA5F3C6);
    pulse_start();
    wait_done("basic", 2000);
    check("basic_valid_cnt", 64'(n_valid - v0), 64'd1);
    check("basic_pos", 64'(position), 64'h4BE78);
    check("basic_status", 64'(status), 64'b110);

    // Start bit never arrives.
    v0 = n_valid;
    t0 = n_to;
    queue_frame(1'b1, 0, '0);
    pulse_start();
    wait_done("timeout", 2000);
    check("to_cnt", 64'(n_to - t0), 64'd1);
    check("to_no_valid", 64'(n_valid - v0), 64'd0);
    check("to_raw_kept", 64'(raw_frame), 64'hA5F3C6);

    // Randomized reads, some of which time out.
    for (int k = 0; k < 8; k++) begin
      f = 24'($urandom);
      queue_frame($urandom_range(0, 4) == 0, int'($urandom_range(0, 6)), f);
      pulse_start();
      wait_done("random", 2000);
    end

    // Three starts during one read: two overruns and exactly one extra read.
    o0 = n_ovr;
    f0 = n_falls;
    queue_frame(1'b0, int'($urandom_range(0, 2)), 24'($urandom));
    queue_frame(1'b0, 0, 24'($urandom));
    pulse_start();
    wait_falls("ovr_frame", f0 + 1, 100);
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(posedge clk);
      pulse_start();
    end
    wait_done("overrun", 3000);
    check("ovr_pulses", 64'(n_ovr - o0), 64'd2);
    check("ovr_reads", 64'(n_falls - f0), 64'd2);

    // Periodic mode, then enable dropped in the middle of the third read.
    f0  = n_falls;
    idx = fall_t.size();
    v0  = n_valid;
    queue_frame(1'b0, 0, 24'h000001);
    queue_frame(1'b0, 0, 24'hFFFFFF);
    queue_frame(1'b0, 0, 24'($urandom));
    @(negedge clk);
    enable = 1'b1;
    wait_falls("periodic", f0 + 3, 4 * PERIOD);
    repeat (60) @(posedge clk);
    #1 enable = 1'b0;
    wait_done("periodic", 2000);
    repeat (2 * PERIOD) @(posedge clk);
    check("per_reads", 64'(n_falls - f0), 64'd3);
    check("per_valids", 64'(n_valid - v0), 64'd3);
    for (i = 1; i < 3; i++) begin
      if (fall_t.size() > idx + i)
        check("per_interval", 64'((fall_t[idx + i] - fall_t[idx + i - 1]) / TCLK), 64'(PERIOD));
    end

    // Reset asserted during the shift phase releases the bus at once.
    queue_frame(1'b0, 1, 24'($urandom));
    pulse_start();
    for (i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (n_falls > 0 && enc_falls >= 12 && cs_n == 1'b0) break;
    end
    check("reach_bit10", 64'(i < 1000), 64'd1);
    #3;
    abort = 1'b1;
    rst   = 1'b1;
    #1;
    check("mid_rst_sck", 64'(sck), 64'd1);
    check("mid_rst_cs_n", 64'(cs_n), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_raw", 64'(raw_frame), 64'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    model_last = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    f = 24'($urandom);
    queue_frame(1'b0, 0, f);
    pulse_start();
    wait_done("after_rst", 2000);
    check("after_rst_raw", 64'(raw_frame), 64'(f));

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
